store_buffer: RTL and testbench

- Posted-write store queue between the single-cycle core's memory stage and the byte-addressable data memory.
- Accepts stores from the core without stalling and drains them into data memory one per cycle, in order.
- Passes loads straight through on the shared single memory port. A load stalls only while it overlaps, at byte level, a store that has not yet been written to memory.

---
 rtl/store_buffer_pkg.sv | 31 +++
 rtl/store_buffer_overlap.sv | 44 ++++
 rtl/store_buffer.sv | 140 ++++++++++++++
 tb/tb_store_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: funct3 encodings, byte-span
// decode and the queued store entry layout.
package store_buffer_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Entry addresses are held at a fixed width; only the low AW bits are significant.
  localparam int unsigned SB_ADDR_MAX = 16;

  typedef logic [SB_ADDR_MAX-1:0] sb_addr_t;

  typedef struct packed {
    sb_addr_t    addr;
    logic [31:0] data;
    logic [2:0]  funct3;
  } sb_entry_t;

  // Unknown encodings are treated as a full word so overlap checks stay conservative.
  function automatic logic [2:0] f3_span(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_span = 3'd1;
      F3_H, F3_HU: f3_span = 3'd2;
      default:     f3_span = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_overlap.sv
// Byte-level overlap test between one store entry and a load, with addresses
// wrapping modulo 2^AW.
module sb_overlap
  import store_buffer_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          ent_valid,
  input  sb_addr_t      ent_addr,
  input  logic [2:0]    ent_funct3,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_funct3,
  output logic          overlap
);

  localparam sb_addr_t AMASK = sb_addr_t'((1 << AW) - 1);

  logic [2:0]  st_span;
  logic [2:0]  ld_span;
  logic [15:0] hit;
  sb_addr_t    st_byte;
  sb_addr_t    ld_byte;

  assign st_span = f3_span(ent_funct3);
  assign ld_span = f3_span(ld_funct3);

  always_comb begin
    hit     = '0;
    st_byte = '0;
    ld_byte = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        st_byte = ent_addr + sb_addr_t'(i);
        ld_byte = sb_addr_t'(ld_addr) + sb_addr_t'(j);
        // Masking to AW bits gives the same wrap as the data memory.
        hit[i*4+j] = (3'(i) < st_span) && (3'(j) < ld_span) &&
                     (((st_byte ^ ld_byte) & AMASK) == '0);
      end
    end
  end

  assign overlap = ent_valid && (|hit);

endmodule

// File: rtl/store_buffer.sv
// Posted-write store queue: absorbs core stores, drains one per cycle in order,
// and lets non-conflicting loads take the single memory port first.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_funct3,
  output logic          st_err,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_funct3,
  output logic          ld_stall,
  output logic [31:0]   ld_data,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [31:0]   mem_rdata,
  output logic          sb_empty
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q, count_d;
  logic          st_err_q;

  logic             st_legal, st_in_valid, enq, pop, ld_go, ovl_any;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH:0]   ovl;
  logic [PW-1:0]    off;
  sb_addr_t         st_in_addr;

  assign st_legal    = st_funct3 inside {F3_B, F3_H, F3_W};
  assign st_ready    = count_q < DEPTH_C;
  assign enq         = st_valid && st_ready && st_legal;
  assign st_in_valid = st_valid && st_legal;
  assign st_in_addr  = sb_addr_t'(st_addr);
  assign sb_empty    = (count_q == '0);
  assign st_err      = st_err_q;

  // Slot validity is derived from its distance to the head, so reset only clears pointers.
  always_comb begin
    ent_valid = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - head_q;
      ent_valid[i] = {1'b0, off} < count_q;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
    sb_overlap #(.AW(AW)) u_ovl (
      .ent_valid  (ent_valid[g]),
      .ent_addr   (ent_q[g].addr),
      .ent_funct3 (ent_q[g].funct3),
      .ld_addr    (ld_addr),
      .ld_funct3  (ld_funct3),
      .overlap    (ovl[g])
    );
  end

  // The store presented this cycle counts as older than the load.
  sb_overlap #(.AW(AW)) u_ovl_in (
    .ent_valid  (st_in_valid),
    .ent_addr   (st_in_addr),
    .ent_funct3 (st_funct3),
    .ld_addr    (ld_addr),
    .ld_funct3  (ld_funct3),
    .overlap    (ovl[DEPTH])
  );

  assign ovl_any  = |ovl;
  assign ld_go    = ld_req && !ovl_any;
  assign pop      = !ld_go && (count_q != '0);
  assign ld_stall = ld_req && ovl_any;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    ld_data    = '0;
    if (ld_go) begin
      mem_read   = 1'b1;
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
      ld_data    = mem_rdata;
    end else if (pop) begin
      mem_write  = 1'b1;
      mem_addr   = ent_q[head_q].addr[AW-1:0];
      mem_wdata  = ent_q[head_q].data;
      mem_funct3 = ent_q[head_q].funct3;
    end
  end

  always_comb begin
    count_d = count_q;
    if (enq && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!enq && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_ONE;
      if (pop) head_q <= head_q + PTR_ONE;
      count_q  <= count_d;
      st_err_q <= st_valid && st_ready && !st_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_q[tail_q] <= '{addr: st_in_addr, data: st_data, funct3: st_funct3};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a 256-byte little-endian data memory model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_valid, st_ready, st_err, ld_req, ld_stall;
  logic [7:0]  st_addr, ld_addr, mem_addr;
  logic [31:0] st_data, ld_data, mem_wdata, mem_rdata;
  logic [2:0]  st_funct3, ld_funct3, mem_funct3;
  logic        mem_read, mem_write, sb_empty;

  logic [7:0]  mem [256];
  logic [7:0]  b0, b1, b2, b3;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_funct3  (st_funct3),
    .st_err     (st_err),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_funct3  (ld_funct3),
    .ld_stall   (ld_stall),
    .ld_data    (ld_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata),
    .sb_empty   (sb_empty)
  );

  // Data memory: combinational read, byte-wrapping, unknown funct3 reads 0.
  always_comb begin
    mem_rdata = '0;
    b0 = mem[mem_addr];
    b1 = mem[mem_addr + 8'd1];
    b2 = mem[mem_addr + 8'd2];
    b3 = mem[mem_addr + 8'd3];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b100:  mem_rdata = {24'd0, b0};
      3'b101:  mem_rdata = {16'd0, b1, b0};
      default: mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_addr + 8'd2] <= mem_wdata[23:16];
        mem[mem_addr + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h44; mem[8'h41] = 8'h33; mem[8'h42] = 8'h22; mem[8'h43] = 8'h11;
    st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
    ld_req = 0; ld_addr = 0; ld_funct3 = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_mwrite", 32'(mem_write), 32'd0);
    chk("rst_err", 32'(st_err), 32'd0);
    step(); step();
    rst_n = 1'b1;

    // sw 0x10, drain, then lw hits memory
    st_valid = 1; st_addr = 8'h10; st_data = 32'hDEADBEEF; st_funct3 = 3'b010;
    @(negedge clk);
    chk("t1_nowrite", 32'(mem_write), 32'd0);
    step(); st_valid = 0;
    @(negedge clk);
    chk("t1_drain_we", 32'(mem_write), 32'd1);
    chk("t1_drain_addr", 32'(mem_addr), 32'h10);
    chk("t1_drain_data", mem_wdata, 32'hDEADBEEF);
    chk("t1_not_empty", 32'(sb_empty), 32'd0);
    step(); ld_req = 1; ld_addr = 8'h10; ld_funct3 = 3'b010;
    @(negedge clk);
    chk("t1_ld_stall", 32'(ld_stall), 32'd0);
    chk("t1_ld_data", ld_data, 32'hDEADBEEF);
    chk("t1_empty", 32'(sb_empty), 32'd1);
    chk("t1_mread", 32'(mem_read), 32'd1);

    // Fill with loads holding the port on a disjoint address
    step(); ld_addr = 8'h40;
    for (int k = 0; k < 4; k++) begin
      st_valid = 1; st_addr = 8'(4 * k); st_data = 32'h1000_0000 + 32'(k);
      st_funct3 = 3'b010;
      @(negedge clk);
      chk("t2_fill_nowrite", 32'(mem_write), 32'd0);
      chk("t2_fill_ld", ld_data, 32'h11223344);
      step();
    end
    st_addr = 8'h50; st_data = 32'h55;
    @(negedge clk);
    chk("t2_full_ready", 32'(st_ready), 32'd0);
    chk("t2_full_nowrite", 32'(mem_write), 32'd0);
    chk("t2_full_ld", ld_data, 32'h11223344);
    step(); st_valid = 0; ld_addr = 8'h41; ld_funct3 = 3'b100;
    @(negedge clk);
    chk("t2_lbu_data", ld_data, 32'h33);
    chk("t2_lbu_nowrite", 32'(mem_write), 32'd0);
    step(); ld_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_drain_we", 32'(mem_write), 32'd1);
      chk("t2_drain_addr", 32'(mem_addr), 32'(4 * k));
      chk("t2_drain_data", mem_wdata, 32'h1000_0000 + 32'(k));
      step();
    end
    @(negedge clk);
    chk("t2_drained_empty", 32'(sb_empty), 32'd1);
    chk("t2_no_extra_write", 32'(mem_write), 32'd0);
    step(); ld_req = 1; ld_addr = 8'h08; ld_funct3 = 3'b010;
    @(negedge clk);
    chk("t2_readback", ld_data, 32'h1000_0002);
    step(); ld_req = 0;

    // sh 0x21 then lbu 0x22: one stall cycle
    st_valid = 1; st_addr = 8'h21; st_data = 32'h1234; st_funct3 = 3'b001;
    step(); st_valid = 0; ld_req = 1; ld_addr = 8'h22; ld_funct3 = 3'b100;
    @(negedge clk);
    chk("t3_stall", 32'(ld_stall), 32'd1);
    chk("t3_stall_data", ld_data, 32'd0);
    chk("t3_drain_addr", 32'(mem_addr), 32'h21);
    chk("t3_drain_we", 32'(mem_write), 32'd1);
    step();
    @(negedge clk);
    chk("t3_resolved", 32'(ld_stall), 32'd0);
    chk("t3_ld_data", ld_data, 32'h12);
    step(); ld_req = 0;

    // sw 0xFE wraps; lb 0x01 presented in the same cycle as the store
    st_valid = 1; st_addr = 8'hFE; st_data = 32'hAABBCCDD; st_funct3 = 3'b010;
    ld_req = 1; ld_addr = 8'h01; ld_funct3 = 3'b000;
    @(negedge clk);
    chk("t4_incoming_stall", 32'(ld_stall), 32'd1);
    chk("t4_no_read", 32'(mem_read), 32'd0);
    step(); st_valid = 0;
    @(negedge clk);
    chk("t4_pending_stall", 32'(ld_stall), 32'd1);
    chk("t4_drain_addr", 32'(mem_addr), 32'hFE);
    step();
    @(negedge clk);
    chk("t4_resolved", 32'(ld_stall), 32'd0);
    chk("t4_lb_data", ld_data, 32'hFFFFFFAA);
    step(); ld_addr = 8'h00; ld_funct3 = 3'b100;
    @(negedge clk);
    chk("t4_wrap_byte", ld_data, 32'hBB);
    step(); ld_req = 0;

    // Illegal funct3 store is dropped with a one-cycle error pulse
    st_valid = 1; st_addr = 8'h30; st_data = 32'h99; st_funct3 = 3'b011;
    @(negedge clk);
    chk("t5_err_before", 32'(st_err), 32'd0);
    step(); st_valid = 0;
    @(negedge clk);
    chk("t5_err_pulse", 32'(st_err), 32'd1);
    chk("t5_empty", 32'(sb_empty), 32'd1);
    chk("t5_nowrite", 32'(mem_write), 32'd0);
    step();
    @(negedge clk);
    chk("t5_err_clear", 32'(st_err), 32'd0);

    // Reset mid-cycle with three stores pending
    step(); ld_req = 1; ld_addr = 8'h40; ld_funct3 = 3'b010;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1; st_addr = 8'h60 + 8'(4 * k); st_data = 32'hC0 + 32'(k);
      st_funct3 = 3'b010;
      step();
    end
    st_valid = 0;
    @(negedge clk);
    chk("t6_pending", 32'(sb_empty), 32'd0);
    #2 rst_n = 1'b0; ld_req = 0;
    #1;
    chk("t6_rst_empty", 32'(sb_empty), 32'd1);
    chk("t6_rst_nowrite", 32'(mem_write), 32'd0);
    chk("t6_rst_ready", 32'(st_ready), 32'd1);
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_nowrite", 32'(mem_write), 32'd0);
    step();
    @(negedge clk);
    chk("t6_after_nowrite2", 32'(mem_write), 32'd0);
    step(); ld_req = 1; ld_addr = 8'h60; ld_funct3 = 3'b010;
    @(negedge clk);
    chk("t6_mem60", ld_data, 32'd0);
    step(); ld_addr = 8'h64;
    @(negedge clk);
    chk("t6_mem64", ld_data, 32'd0);
    step(); ld_req = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
